stream_xbar_datapath: RTL
=========================

Name: stream_xbar_datapath

Overview:
Second-generation data path of the stream crossbar. It connects S_DATA_COUNT input streams to M_DATA_COUNT output streams using per-output grants from the arbiter unit. Each output locks to one source for a whole packet, so routing is packet-atomic. Every output has a parametrised FIFO, and both sides use a full valid/ready handshake with true backpressure.

Parameters:
T_DATA_WIDTH, 8, data bits per beat
S_DATA_COUNT, 2, number of input (source) streams, >=2
M_DATA_COUNT, 3, number of output (sink) streams, >=2
OUT_FIFO_DEPTH, 2, beats per output FIFO; power of two, >=2
localparam T_ID___WIDTH = $clog2(S_DATA_COUNT); T_DEST_WIDTH = $clog2(M_DATA_COUNT)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
s_data_i  in  [T_DATA_WIDTH] x S_DATA_COUNT  source data
s_dest_i  in  [T_DEST_WIDTH] x S_DATA_COUNT  source destination; held stable for a whole packet
s_last_i  in  S_DATA_COUNT  last beat of packet
s_valid_i  in  S_DATA_COUNT  source beat valid
s_ready_o  out  S_DATA_COUNT  source beat accepted when valid&ready
m_data_o  out  [T_DATA_WIDTH] x M_DATA_COUNT  output data
m_id_o  out  [T_ID___WIDTH] x M_DATA_COUNT  index of the source that produced the beat
m_last_o  out  M_DATA_COUNT  last beat
m_valid_o  out  M_DATA_COUNT  output beat valid
m_ready_i  in  M_DATA_COUNT  sink ready
grant_i  in  [T_ID___WIDTH] x M_DATA_COUNT  arbiter-selected source per output
grant_valid_i  in  M_DATA_COUNT  grant_i[i] is meaningful
grant_ack_o  out  M_DATA_COUNT  1-cycle pulse: packet on output i fully accepted, output free for re-arbitration

Behaviour:
- Reset (rst_i=1, asynchronous): all outputs IDLE, FIFOs empty, lock ids 0, grant_ack_o=0, s_ready_o=0, m_valid_o=0. m_data_o, m_id_o and m_last_o read 0.
- While m_valid_o[i]=0, m_data_o[i], m_id_o[i] and m_last_o[i] are forced to 0. This prevents X or stale data leaking.
- Per-output FSM with states IDLE and LOCKED; lock register lock_id[i].
- IDLE->LOCKED when grant_valid_i[i] && s_valid_i[g] && s_dest_i[g]==i, where g=grant_i[i]. lock_id[i]<=g.
- A grant whose source is not valid, or whose source's dest != i, is ignored: the FSM stays IDLE and no ack is issued. This replaces first-generation X-grant filtering.
- LOCKED: s_ready_o[lock_id[i]] = FIFO i not full. A beat is pushed on s_valid&s_ready of the locked source.
- Push of a beat with s_last=1: LOCKED->IDLE on the same edge, and grant_ack_o[i]=1 for exactly the next cycle.
- s_ready_o[j] = OR over outputs locked to j. At most one output may be locked to a source, enforced by the dest check; the bench asserts this.
- s_ready_o[j]=0 for any source not locked by any output.
- The lock cycle does not accept a beat. The first beat of a packet is accepted at the earliest 1 cycle after the grant is seen.
- FIFO i is first-word-fall-through and stores {lock_id, data, last}.
- A beat pushed at edge t is visible on m_*_o from cycle t+1. m_valid_o[i] = !empty. Pop on m_valid_o&m_ready_i.
- Full FIFO: s_ready low. Simultaneous pop and push on a full FIFO is not permitted, because ready depends only on !full; no combinational m_ready->s_ready path. Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo OUT_FIFO_DEPTH; count is $clog2(depth)+1 bits.
- grant_i and grant_valid_i are ignored while LOCKED; the arbiter may change them freely.
- Sustained throughput is 1 beat/cycle per output when the sink is always ready. Packet-to-packet gap is 1 idle cycle (re-lock).
- Reset mid-packet: the packet is discarded, FIFOs are flushed, and no ack is issued.

Decomposition:
- Package stream_xbar_pkg holds the FSM state enum (XBAR_IDLE, XBAR_LOCKED) and a clog2-safe width function shared with the arbiter unit.
- Sub-module stream_out_fifo (parametrised width/depth, FWFT, async active-high reset) is instantiated once per output.
- Routing and FSMs are generated in the top.

Test Plan:
- Src0 sends a 3-beat packet (0xA1,0xA2,0xA3, dest=2), grant_i[2]=0, sink ready -> m_data_o[2] shows A1,A2,A3 on consecutive cycles, m_id_o[2]=0, m_last_o on A3, grant_ack_o[2] pulses once.
- m_ready_i[1]=0 with depth 2 while src1 streams 4 beats to output 1 -> s_ready_o[1] drops after 2 beats. After ready rises, all 4 beats arrive in order with no loss or duplication.
- grant_i[0]=1 with grant_valid, but src1 dest=2 -> output 0 stays IDLE, s_ready_o[1]=0, no ack on output 0.
- Src0 to out0 and src1 to out1 concurrently -> both outputs carry 1 beat/cycle independently with correct m_id_o.
- Grant changes mid-packet on out0 (src0 locked, grant_i[0] switched to 1) -> output stays on src0 until last, then re-locks src1 after 1 idle cycle.
- rst_i pulsed asynchronously mid-packet -> m_valid_o, s_ready_o and grant_ack_o go 0 immediately. A new packet after release routes correctly.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar data path and arbiter.
package stream_xbar_pkg;

    // Per-output routing state: waiting for a grant, or bound to one source.
    typedef enum logic {
        XBAR_IDLE   = 1'b0,
        XBAR_LOCKED = 1'b1
    } xbar_state_t;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_out_fifo.sv
// First-word-fall-through FIFO used once per crossbar output.
module stream_out_fifo
    import stream_xbar_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = clog2_safe(DEPTH)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_wr    = push_i && !full_o;
    assign w_rd    = pop_i && !empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    // Storage has no reset: stale entries are never visible because count gates them.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/stream_xbar_datapath.sv
// Packet-atomic crossbar data path: each output locks to one granted source
// until that source's last beat, buffering beats in a per-output FIFO.
module stream_xbar_datapath
    import stream_xbar_pkg::*;
#(
    parameter  int T_DATA_WIDTH   = 8,
    parameter  int S_DATA_COUNT   = 2,
    parameter  int M_DATA_COUNT   = 3,
    parameter  int OUT_FIFO_DEPTH = 2,
    localparam int T_ID___WIDTH   = clog2_safe(S_DATA_COUNT),
    localparam int T_DEST_WIDTH   = clog2_safe(M_DATA_COUNT)
)(
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    output logic [S_DATA_COUNT-1:0]                   s_ready_o,
    output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
    output logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o,
    output logic [M_DATA_COUNT-1:0]                   m_last_o,
    output logic [M_DATA_COUNT-1:0]                   m_valid_o,
    input  logic [M_DATA_COUNT-1:0]                   m_ready_i,
    input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_i,
    input  logic [M_DATA_COUNT-1:0]                   grant_valid_i,
    output logic [M_DATA_COUNT-1:0]                   grant_ack_o
);

    localparam int FIFO_W = T_ID___WIDTH + T_DATA_WIDTH + 1;

    logic [M_DATA_COUNT-1:0]                   w_locked;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] w_lock_id;
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] w_ready_sel;

    genvar gi, gj;
    generate
        for (gi = 0; gi < M_DATA_COUNT; gi++) begin : gen_out
            xbar_state_t       r_state;
            xbar_state_t       w_state_next;
            logic [T_ID___WIDTH-1:0] r_lock_id;
            logic              r_ack;
            logic [T_ID___WIDTH-1:0] w_grant;
            logic              w_grant_ok;
            logic              w_lock_req;
            logic              w_src_valid;
            logic              w_src_last;
            logic              w_push;
            logic              w_pop;
            logic              w_full;
            logic              w_empty;
            logic [FIFO_W-1:0] w_fifo_in;
            logic [FIFO_W-1:0] w_fifo_out;

            // A grant only counts if its source is presenting a packet aimed here.
            assign w_grant     = grant_i[gi];
            assign w_grant_ok  = (32'(w_grant) < S_DATA_COUNT);
            assign w_lock_req  = grant_valid_i[gi] && w_grant_ok && s_valid_i[w_grant]
                                 && (s_dest_i[w_grant] == T_DEST_WIDTH'(gi));
            assign w_src_valid = s_valid_i[r_lock_id];
            assign w_src_last  = s_last_i[r_lock_id];
            assign w_push      = (r_state == XBAR_LOCKED) && w_src_valid && !w_full;
            assign w_pop       = !w_empty && m_ready_i[gi];

            // Routing state register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_state <= XBAR_IDLE;
                end else begin
                    r_state <= w_state_next;
                end
            end

            // Lock on an accepted grant; release on the pushed last beat.
            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    XBAR_IDLE:   if (w_lock_req) w_state_next = XBAR_LOCKED;
                    XBAR_LOCKED: if (w_push && w_src_last) w_state_next = XBAR_IDLE;
                    default:     w_state_next = XBAR_IDLE;
                endcase
            end

            // Capture the locked source and pulse ack after the last beat is taken.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_lock_id <= '0;
                    r_ack     <= 1'b0;
                end else begin
                    r_ack <= w_push && w_src_last;
                    if ((r_state == XBAR_IDLE) && w_lock_req) begin
                        r_lock_id <= w_grant;
                    end
                end
            end

            assign w_fifo_in = {r_lock_id, s_data_i[r_lock_id], w_src_last};

            stream_out_fifo #(
                .WIDTH (FIFO_W),
                .DEPTH (OUT_FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .push_i  (w_push),
                .data_i  (w_fifo_in),
                .pop_i   (w_pop),
                .data_o  (w_fifo_out),
                .full_o  (w_full),
                .empty_o (w_empty)
            );

            // Payload is zeroed whenever no beat is presented.
            assign m_valid_o[gi] = !w_empty;
            assign {m_id_o[gi], m_data_o[gi], m_last_o[gi]} = w_empty ? '0 : w_fifo_out;
            assign grant_ack_o[gi] = r_ack;
            assign w_locked[gi]    = (r_state == XBAR_LOCKED);
            assign w_lock_id[gi]   = r_lock_id;

            for (gj = 0; gj < S_DATA_COUNT; gj++) begin : gen_sel
                assign w_ready_sel[gj][gi] = w_locked[gi]
                                             && (r_lock_id == T_ID___WIDTH'(gj)) && !w_full;
            end
        end

        for (gj = 0; gj < S_DATA_COUNT; gj++) begin : gen_ready
            assign s_ready_o[gj] = |w_ready_sel[gj];
        end
    endgenerate

endmodule
